// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use bubble insertion
// and a multi-cycle-op stall sequencer. Optional statistics under HAZARD_STATS_EN.
module hazard_ctrl_unit #(
  parameter int unsigned AW     = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    if_id_rs,
  input  logic [AW-1:0]    if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic [AW-1:0]    id_ex_rs,
  input  logic [AW-1:0]    id_ex_rt,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_mc_start,
  input  logic [AW-1:0]    ex_mem_rd,
  input  logic [AW-1:0]    mem_wb_rd,
  input  logic             ex_mem_reg_write,
  input  logic             mem_wb_reg_write,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_flush,
  output logic             ex_stall,
  output logic             mc_done,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] mc_stall_cnt
);

  localparam int unsigned CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 2);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lu_c;
  logic          lu_stall;

  // EX/MEM has priority over MEM/WB; register 0 never forwards
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] src,
    input logic          em_we,
    input logic [AW-1:0] em_rd,
    input logic          mw_we,
    input logic [AW-1:0] mw_rd
  );
    if (em_we && (em_rd != '0) && (em_rd == src))
      return 2'b10;
    else if (mw_we && (mw_rd != '0) && (mw_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (!reset) begin
      forward_a = fwd_sel(id_ex_rs, ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd);
      forward_b = fwd_sel(id_ex_rt, ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd);
    end
  end

  assign lu_c = id_ex_mem_read && (id_ex_rt != '0) &&
                ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mealy stall decode; reset forces the quiescent outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_flush = 1'b0;
    ex_stall    = 1'b0;
    mc_done     = 1'b0;
    lu_stall    = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (id_ex_mc_start) begin
            ex_stall    = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            cnt_d       = CNT_LOAD;
            state_d     = MC_BUSY;
          end else if (lu_c) begin
            lu_stall = 1'b1;
          end
        end
        MC_BUSY: begin
          if (cnt_q != '0) begin
            ex_stall    = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            cnt_d       = cnt_q - CW'(1);
          end else begin
            // release cycle: held op's mc_start is ignored
            mc_done = 1'b1;
            state_d = IDLE;
            lu_stall = lu_c;
          end
        end
        default: state_d = IDLE;
      endcase
      if (lu_stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] load_cnt_q, mc_cnt_q;

  // saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_q <= '0;
      mc_cnt_q   <= '0;
    end else begin
      if (lu_stall && (load_cnt_q != '1))
        load_cnt_q <= load_cnt_q + CNT_W'(1);
      if (ex_stall && (mc_cnt_q != '1))
        mc_cnt_q <= mc_cnt_q + CNT_W'(1);
    end
  end

  assign load_stall_cnt = load_cnt_q;
  assign mc_stall_cnt   = mc_cnt_q;
`else
  assign load_stall_cnt = '0;
  assign mc_stall_cnt   = '0;
`endif

endmodule
